// File: rtl/df_zoom_pipe_pkg.sv
// +----------------------------------------------------------------------+
// | df_zoom_pipe_pkg: shared widths and pass-mode encoding for the filter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package df_zoom_pipe_pkg;

  localparam int c_NP_DEF = 16;  // raw timestamp width
  localparam int c_NB_DEF = 8;   // histogram bin index width
  localparam int c_CW_DEF = 16;  // per-frame counter width

  typedef enum logic {
    MODE_ZOOM   = 1'b0,
    MODE_COARSE = 1'b1
  } mode_e;

endpackage

`default_nettype wire

// File: rtl/df_bin_map.sv
// +----------------------------------------------------------------------+
// | df_bin_map: window test, clamped offset subtract, shift, overflow    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module df_bin_map
  import df_zoom_pipe_pkg::*;
#(
  parameter int NP = c_NP_DEF,
  parameter int NB = c_NB_DEF,
  parameter int SW = $clog2(NP)
) (
  input  logic          coarse_i,
  input  logic [NP-1:0] data_i,
  input  logic [NP-1:0] th_lo_i,
  input  logic [NP-1:0] th_hi_i,
  input  logic [NP-1:0] delta_i,
  input  logic [SW-1:0] shift_i,
  output logic          keep_o,
  output logic [NP-1:0] diff_o,
  output logic [SW-1:0] sh_o,
  input  logic [NP-1:0] s2_diff_i,
  input  logic [SW-1:0] s2_sh_i,
  output logic [NB-1:0] bin_o,
  output logic          ovf_o
);

  localparam logic [SW-1:0] c_COARSE_SH = SW'(NP - NB);

  logic [NP-1:0] w_full;

  // First-stage half: decides whether the sample survives and what to shift.
  always_comb begin
    keep_o = 1'b1;
    diff_o = data_i;
    sh_o   = c_COARSE_SH;
    if (!coarse_i) begin
      keep_o = (data_i >= th_lo_i) && (data_i <= th_hi_i);
      diff_o = (data_i >= delta_i) ? (data_i - delta_i) : '0;
      sh_o   = shift_i;
    end
  end

  assign w_full = s2_diff_i >> s2_sh_i;
  assign bin_o  = w_full[NB-1:0];

  generate
    if (NB < NP) begin : g_ovf
      assign ovf_o = |w_full[NP-1:NB];
    end else begin : g_no_ovf
      assign ovf_o = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/df_zoom_pipe.sv
// +----------------------------------------------------------------------+
// | df_zoom_pipe: TDC timestamp to histogram bin, two-stage valid/ready  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module df_zoom_pipe
  import df_zoom_pipe_pkg::*;
#(
  parameter int NP = c_NP_DEF,
  parameter int NB = c_NB_DEF,
  parameter int SW = $clog2(NP),
  parameter int CW = c_CW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          frame_start_i,
  input  logic          coarse_mode_i,
  input  logic [NP-1:0] th_lo_i,
  input  logic [NP-1:0] th_hi_i,
  input  logic [NP-1:0] delta_i,
  input  logic [SW-1:0] shift_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [NP-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [NB-1:0] out_bin_o,
  output logic [CW-1:0] acc_cnt_o,
  output logic [CW-1:0] rej_cnt_o,
  output logic          busy_o,
  output logic          cfg_err_o
);

  localparam logic [SW-1:0] c_RST_SHIFT = SW'(NP - NB);

  mode_e         cfg_mode_q;
  logic [NP-1:0] cfg_lo_q, cfg_hi_q, cfg_delta_q;
  logic [SW-1:0] cfg_shift_q;

  logic          s1_valid_q, s1_valid_d;
  logic [NP-1:0] s1_diff_q, s1_diff_d;
  logic [SW-1:0] s1_sh_q, s1_sh_d;
  logic          out_valid_q, out_valid_d;
  logic [NB-1:0] out_bin_q, out_bin_d;
  logic [CW-1:0] acc_q, acc_d, rej_q, rej_d;
  logic          cfg_err_q, cfg_err_d;

  logic          w_keep, w_ovf;
  logic [NP-1:0] w_diff;
  logic [SW-1:0] w_sh;
  logic [NB-1:0] w_bin;
  logic          w_busy, w_fs_take, w_s2_hold, w_accept;
  logic          w_s1_rej, w_s2_fire, w_s2_acc, w_s2_rej;
  logic [1:0]    w_rej_inc;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [1:0] inc);
    logic [CW:0] sum;
    sum = {1'b0, a} + (CW+1)'(inc);
    return sum[CW] ? '1 : sum[CW-1:0];
  endfunction

  df_bin_map #(.NP(NP), .NB(NB), .SW(SW)) u_map (
    .coarse_i  (cfg_mode_q == MODE_COARSE),
    .data_i    (in_data_i),
    .th_lo_i   (cfg_lo_q),
    .th_hi_i   (cfg_hi_q),
    .delta_i   (cfg_delta_q),
    .shift_i   (cfg_shift_q),
    .keep_o    (w_keep),
    .diff_o    (w_diff),
    .sh_o      (w_sh),
    .s2_diff_i (s1_diff_q),
    .s2_sh_i   (s1_sh_q),
    .bin_o     (w_bin),
    .ovf_o     (w_ovf)
  );

  assign w_busy    = s1_valid_q | out_valid_q;
  assign w_fs_take = frame_start_i & ~w_busy;
  assign w_s2_hold = out_valid_q & ~out_ready_i;
  // Intake pauses on a config load so no sample straddles two configurations.
  assign in_ready_o = rst_ni & ~w_fs_take & ~(s1_valid_q & w_s2_hold);
  assign w_accept   = in_valid_i & in_ready_o;
  assign w_s1_rej   = w_accept & ~w_keep;
  assign w_s2_fire  = s1_valid_q & ~w_s2_hold;
  assign w_s2_acc   = w_s2_fire & ~w_ovf;
  assign w_s2_rej   = w_s2_fire & w_ovf;
  assign w_rej_inc  = {1'b0, w_s1_rej} + {1'b0, w_s2_rej};

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_diff_d   = s1_diff_q;
    s1_sh_d     = s1_sh_q;
    out_valid_d = out_valid_q;
    out_bin_d   = out_bin_q;
    if (w_accept) begin
      s1_valid_d = w_keep;
      s1_diff_d  = w_diff;
      s1_sh_d    = w_sh;
    end else if (!w_s2_hold) begin
      s1_valid_d = 1'b0;
    end
    if (!w_s2_hold) begin
      out_valid_d = w_s2_acc;
      if (w_s2_acc) begin
        out_bin_d = w_bin;
      end
    end
    acc_d     = w_fs_take ? '0 : sat_add(acc_q, {1'b0, w_s2_acc});
    rej_d     = w_fs_take ? '0 : sat_add(rej_q, w_rej_inc);
    cfg_err_d = cfg_err_q | (frame_start_i & w_busy);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cfg_mode_q  <= MODE_COARSE;
      cfg_lo_q    <= '0;
      cfg_hi_q    <= '1;
      cfg_delta_q <= '0;
      cfg_shift_q <= c_RST_SHIFT;
      s1_valid_q  <= 1'b0;
      s1_diff_q   <= '0;
      s1_sh_q     <= '0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      acc_q       <= '0;
      rej_q       <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      if (w_fs_take) begin
        cfg_mode_q  <= coarse_mode_i ? MODE_COARSE : MODE_ZOOM;
        cfg_lo_q    <= th_lo_i;
        cfg_hi_q    <= th_hi_i;
        cfg_delta_q <= delta_i;
        cfg_shift_q <= shift_i;
      end
      s1_valid_q  <= s1_valid_d;
      s1_diff_q   <= s1_diff_d;
      s1_sh_q     <= s1_sh_d;
      out_valid_q <= out_valid_d;
      out_bin_q   <= out_bin_d;
      acc_q       <= acc_d;
      rej_q       <= rej_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_bin_o   = out_bin_q;
  assign acc_cnt_o   = acc_q;
  assign rej_cnt_o   = rej_q;
  assign busy_o      = w_busy;
  assign cfg_err_o   = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_df_zoom_pipe.sv
// +----------------------------------------------------------------------+
// | tb_df_zoom_pipe: vector table, corner sequences and random stream    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_df_zoom_pipe;

  logic        clk = 1'b0;
  logic        rst_n, frame_start, coarse_mode, in_valid, in_ready;
  logic [15:0] th_lo, th_hi, delta, in_data;
  logic [3:0]  shift;
  logic        out_valid, out_ready, busy, cfg_err;
  logic [7:0]  out_bin;
  logic [15:0] acc_cnt, rej_cnt;

  always #5 clk = ~clk;

  df_zoom_pipe #(.NP(16), .NB(8), .SW(4), .CW(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .frame_start_i(frame_start), .coarse_mode_i(coarse_mode),
    .th_lo_i(th_lo), .th_hi_i(th_hi), .delta_i(delta), .shift_i(shift),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_bin_o(out_bin),
    .acc_cnt_o(acc_cnt), .rej_cnt_o(rej_cnt), .busy_o(busy), .cfg_err_o(cfg_err)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the configuration in force and the bins still owed.
  int m_coarse, m_lo, m_hi, m_delta, m_shift, m_acc, m_rej, n_emit, mon_b;
  int exp_q[$];
  int tx_q[$];

  function automatic int ref_bin(int x);
    int d;
    if (m_coarse != 0) return x / 256;
    if (x < m_lo || x > m_hi) return -1;
    d = (x >= m_delta) ? x - m_delta : 0;
    d = d / (1 << m_shift);
    return (d > 255) ? -1 : d;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_coarse = 1; m_lo = 0; m_hi = 65535; m_delta = 0; m_shift = 8;
      m_acc = 0; m_rej = 0;
    end else begin
      if (frame_start && !busy) begin
        m_coarse = int'(coarse_mode); m_lo = int'(th_lo); m_hi = int'(th_hi);
        m_delta = int'(delta); m_shift = int'(shift); m_acc = 0; m_rej = 0;
      end
      if (out_valid && out_ready) begin
        n_emit++;
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_output: got bin 0x%0h, expected none", out_bin);
        end else begin
          chk("stream_bin", out_bin, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        mon_b = ref_bin(int'(in_data));
        if (mon_b < 0) m_rej++;
        else begin m_acc++; exp_q.push_back(mon_b); end
      end
    end
  end

  task automatic do_fs(input int c, input int lo, input int hi, input int d, input int sh);
    @(posedge clk); #1;
    frame_start = 1'b1; coarse_mode = c[0]; th_lo = 16'(lo); th_hi = 16'(hi);
    delta = 16'(d); shift = 4'(sh); in_valid = 1'b0;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic drive(input int max_cyc, input int vpct, input int rpct);
    bit done = 0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(posedge clk); #1;
      in_valid = (tx_q.size() > 0) && ($urandom_range(0, 99) < vpct);
      if (tx_q.size() > 0) in_data = 16'(tx_q[0]);
      out_ready = ($urandom_range(0, 99) < rpct);
      @(negedge clk);
      if (in_valid && in_ready) void'(tx_q.pop_front());
      else if (tx_q.size() == 0 && !busy) done = 1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    chk("drain_done", done, 1);
    chk("model_queue_empty", exp_q.size(), 0);
  endtask

  task automatic stall_cycles(input int n, input bit rdy, output int n_acc);
    n_acc = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      in_valid = (tx_q.size() > 0);
      if (tx_q.size() > 0) in_data = 16'(tx_q[0]);
      out_ready = rdy;
      @(negedge clk);
      if (in_valid && in_ready) begin void'(tx_q.pop_front()); n_acc++; end
    end
  endtask

  typedef struct {
    int fs, coarse, lo, hi, delta, sh, data, vld, bin, acc, rej;
  } vec_t;
  vec_t vt[14];

  initial begin
    int na, lo, span;
    vt[0]  = '{0, 1, 0,      0,      0,      0,  'hABCD, 1, 'hAB, 1, 0};
    vt[1]  = '{1, 0, 'h1000, 'h10FF, 'h1000, 0,  'h1042, 1, 'h42, 1, 0};
    vt[2]  = '{0, 0, 0,      0,      0,      0,  'h1100, 0, 0,    1, 1};
    vt[3]  = '{1, 0, 'h1000, 'h1FFF, 'h1000, 0,  'h1200, 0, 0,    0, 1};
    vt[4]  = '{1, 0, 'h1000, 'h1FFF, 'h1000, 2,  'h1200, 1, 'h80, 1, 0};
    vt[5]  = '{0, 0, 0,      0,      0,      0,  'h1000, 1, 'h00, 2, 0};
    vt[6]  = '{0, 0, 0,      0,      0,      0,  'h1FFF, 0, 0,    2, 1};
    vt[7]  = '{0, 0, 0,      0,      0,      0,  'h0FFF, 0, 0,    2, 2};
    vt[8]  = '{1, 0, 0,      'hFFFF, 'h5000, 0,  'h0100, 1, 'h00, 1, 0};
    vt[9]  = '{0, 0, 0,      0,      0,      0,  'h50FF, 1, 'hFF, 2, 0};
    vt[10] = '{0, 0, 0,      0,      0,      0,  'h5100, 0, 0,    2, 1};
    vt[11] = '{1, 0, 0,      'hFFFF, 0,      15, 'hFFFF, 1, 'h01, 1, 0};
    vt[12] = '{1, 1, 0,      0,      0,      0,  'h00FF, 1, 'h00, 1, 0};
    vt[13] = '{1, 0, 'h2000, 'h1000, 0,      0,  'h1800, 0, 0,    0, 1};

    rst_n = 1'b0; frame_start = 1'b0; coarse_mode = 1'b0; th_lo = '0; th_hi = '0;
    delta = '0; shift = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    n_emit = 0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acc", acc_cnt, 0);
    chk("rst_rej", rej_cnt, 0);
    chk("rst_cfg_err", cfg_err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Vector table: one sample per entry, fixed two-cycle latency
    foreach (vt[i]) begin
      if (vt[i].fs != 0) do_fs(vt[i].coarse, vt[i].lo, vt[i].hi, vt[i].delta, vt[i].sh);
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 16'(vt[i].data); out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, 1);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d_lat1_idle", i), out_valid, 0);
      @(negedge clk);
      chk($sformatf("tbl%0d_out_valid", i), out_valid, vt[i].vld);
      if (vt[i].vld != 0) chk($sformatf("tbl%0d_bin", i), out_bin, vt[i].bin);
      @(negedge clk); @(negedge clk);
      chk($sformatf("tbl%0d_acc", i), acc_cnt, vt[i].acc);
      chk($sformatf("tbl%0d_rej", i), rej_cnt, vt[i].rej);
    end

    // Window miss at s1 and overflow at s2 in the same cycle
    do_fs(0, 'h1000, 'h1FFF, 'h1000, 0);
    @(posedge clk); #1 in_valid = 1'b1; in_data = 16'h1200;
    @(posedge clk); #1 in_data = 16'h0500;
    @(negedge clk);
    chk("dual_rej_before", rej_cnt, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("dual_rej_after", rej_cnt, 2);
    chk("dual_rej_no_out", out_valid, 0);

    // Backpressure: six back-to-back samples against a stalled sink
    do_fs(1, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) tx_q.push_back(k * 256 + k);
    stall_cycles(5, 1'b0, na);
    chk("stall_accepted", na, 2);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_bin_held", out_bin, 1);
    na = n_emit;
    drive(200, 100, 100);
    chk("stall_emitted", n_emit - na, 6);
    chk("stall_acc", acc_cnt, 6);

    // frame_start while busy is ignored and flagged; when idle it reloads
    do_fs(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) tx_q.push_back('h3000 + k * 256);
    stall_cycles(3, 1'b0, na);
    do_fs(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("busy_fs_cfg_err", cfg_err, 1);
    chk("busy_fs_acc", acc_cnt, 1);
    chk("busy_fs_rej", rej_cnt, 0);
    drive(200, 100, 100);
    chk("busy_fs_old_cfg_acc", acc_cnt, 3);
    do_fs(0, 'h1000, 'h10FF, 'h1000, 0);
    @(negedge clk);
    chk("idle_fs_acc_clr", acc_cnt, 0);
    chk("idle_fs_rej_clr", rej_cnt, 0);
    tx_q.push_back('h1042);
    tx_q.push_back('h2000);
    drive(100, 100, 100);
    chk("idle_fs_new_acc", acc_cnt, 1);
    chk("idle_fs_new_rej", rej_cnt, 1);
    chk("cfg_err_sticky", cfg_err, 1);

    // Reset in the middle of a stream
    for (int k = 0; k < 6; k++) tx_q.push_back('h1010 + k);
    stall_cycles(3, 1'b1, na);
    @(posedge clk); #1 rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tx_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_acc", acc_cnt, 0);
    chk("midrst_rej", rej_cnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cfg_err", cfg_err, 0);
    tx_q.push_back('hABCD);
    drive(100, 100, 100);
    chk("midrst_coarse_acc", acc_cnt, 1);

    // Random frames against the model under random valid/ready gaps
    for (int f = 0; f < 5; f++) begin
      lo   = int'($urandom_range(0, 'hC000));
      span = int'($urandom_range(0, 'h3FFF));
      do_fs(($urandom_range(0, 3) == 0) ? 1 : 0, lo, lo + span,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 'hFFFF)) : lo,
            int'($urandom_range(0, 6)));
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 9) < 7)
          tx_q.push_back((lo + int'($urandom_range(0, span + 256)) - 128) & 'hFFFF);
        else
          tx_q.push_back(int'($urandom_range(0, 'hFFFF)));
      end
      drive(3000, 75, 60);
      chk($sformatf("rnd%0d_acc", f), acc_cnt, m_acc);
      chk($sformatf("rnd%0d_rej", f), rej_cnt, m_rej);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
